// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial link: default word width and PISO state encoding.
// Also used by the downstream SIPO stage and its bench.
package serial_link_pkg;

  localparam int unsigned SER_WIDTH = 4;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage : serial_link_pkg

// File: rtl/piso_serializer_if.sv
// Load handshake and serial output bundle of the PISO stage.
// The master drives words in; the slave is the serializer.
interface piso_serializer_if
  import serial_link_pkg::*;
#(
  parameter int unsigned WIDTH = SER_WIDTH
) ();

  logic [WIDTH-1:0] din;
  logic             load_valid;
  logic             load_ready;
  logic             a;
  logic             a_valid;
  logic             frame_start;
  logic             frame_last;

  modport master (
    output din,
    output load_valid,
    input  load_ready,
    input  a,
    input  a_valid,
    input  frame_start,
    input  frame_last
  );

  modport slave (
    input  din,
    input  load_valid,
    output load_ready,
    output a,
    output a_valid,
    output frame_start,
    output frame_last
  );

endinterface : piso_serializer_if

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage feeding the SIPO serial input, one bit per clock.
// Back-to-back words stream without a gap when load_valid is held.
module piso_serializer
  import serial_link_pkg::*;
#(
  parameter int unsigned WIDTH      = SER_WIDTH,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input logic               clk,
  input logic               rst_n,
  piso_serializer_if.slave  bus
);

  localparam int unsigned   CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  logic [0:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;

  logic last_bit;
  logic load_ready;
  logic transfer;

  assign last_bit   = (state_q == ST_SHIFT) && (cnt_q == CntLast);
  // Ready on the last bit lets the next word follow with no idle bubble.
  assign load_ready = (state_q == ST_IDLE) || last_bit;
  assign transfer   = bus.load_valid && load_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (transfer) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (!last_bit) begin
          cnt_d = cnt_q + CntW'(1);
        end else if (transfer) begin
          cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_comb begin
    sr_d = sr_q;
    if (transfer) begin
      sr_d = bus.din;
    end else if ((state_q == ST_SHIFT) && !last_bit) begin
      if (MSB_FIRST) begin
        sr_d = {sr_q[WIDTH-2:0], 1'b0};
      end else begin
        sr_d = {1'b0, sr_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
    end
  end

  // Outputs decode registered state only, so an async reset clears them at once.
  always_comb begin
    bus.load_ready  = load_ready;
    bus.a_valid     = (state_q == ST_SHIFT);
    bus.frame_start = (state_q == ST_SHIFT) && (cnt_q == '0);
    bus.frame_last  = last_bit;
    if (state_q == ST_SHIFT) begin
      bus.a = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
    end else begin
      bus.a = IDLE_LEVEL;
    end
  end

endmodule : piso_serializer
